// File: rtl/midi_pkg.sv
// Shared MIDI constants, decoder state encoding and the data-byte-count helper.
package midi_pkg;

  localparam logic [3:0] NOTE_OFF = 4'h8;
  localparam logic [3:0] NOTE_ON  = 4'h9;
  localparam logic [3:0] POLY_AT  = 4'hA;
  localparam logic [3:0] CTRL     = 4'hB;
  localparam logic [3:0] PROG     = 4'hC;
  localparam logic [3:0] CHAN_AT  = 4'hD;
  localparam logic [3:0] PITCH    = 4'hE;

  localparam logic [6:0] ALL_SOUND_OFF = 7'd120;
  localparam logic [6:0] ALL_NOTES_OFF = 7'd123;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_D1 = 2'd1,
    WAIT_D2 = 2'd2
  } state_t;

  function automatic logic [1:0] data_bytes(input logic [3:0] typ);
    return (typ == PROG || typ == CHAN_AT) ? 2'd1 : 2'd2;
  endfunction

endpackage

// File: rtl/midi_decoder.sv
// MIDI byte-stream parser: running status, channel filter, monophonic
// last-note-priority note/velocity/program registers for the oscillator stage.
module midi_decoder
  import midi_pkg::*;
#(
  parameter int CHANNEL = 0
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_rx_data,
  input  logic       i_rx_valid,
  output logic [6:0] o_note_num,
  output logic [6:0] o_note_vel,
  output logic [6:0] o_program,
  output logic       o_gate,
  output logic       o_note_stb
);

  state_t     r_state, w_state_nx;
  logic [3:0] r_type, w_type_nx;
  logic       r_match, w_match_nx;
  logic [6:0] r_d1, w_d1_nx;
  logic [6:0] r_note_num, w_num_nx;
  logic [6:0] r_note_vel, w_vel_nx;
  logic [6:0] r_program, w_prog_nx;
  logic       r_gate, w_gate_nx;
  logic       r_note_stb, w_stb_nx;
  logic       w_exec;
  logic [6:0] w_e_d1, w_e_d2;
  logic [3:0] w_chan;

  assign w_chan = CHANNEL[3:0];
  // D1 comes straight off the bus for 1-byte messages, from the latch otherwise
  assign w_e_d1 = (r_state == WAIT_D1) ? i_rx_data[6:0] : r_d1;
  assign w_e_d2 = i_rx_data[6:0];

  always_comb begin
    w_state_nx = r_state;
    w_type_nx  = r_type;
    w_match_nx = r_match;
    w_d1_nx    = r_d1;
    w_exec     = 1'b0;
    if (i_rx_valid) begin
      if (i_rx_data[7]) begin
        if (i_rx_data[7:4] != 4'hF) begin
          w_type_nx  = i_rx_data[7:4];
          w_match_nx = (i_rx_data[3:0] == w_chan);
          w_state_nx = WAIT_D1;
        end else if (!i_rx_data[3]) begin
          w_state_nx = IDLE;
        end
        // 0xF8-0xFF realtime: no effect at all
      end else begin
        case (r_state)
          WAIT_D1: begin
            w_d1_nx = i_rx_data[6:0];
            if (data_bytes(r_type) == 2'd1) w_exec = 1'b1;
            else                            w_state_nx = WAIT_D2;
          end
          WAIT_D2: begin
            w_exec     = 1'b1;
            w_state_nx = WAIT_D1;
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    w_num_nx  = r_note_num;
    w_vel_nx  = r_note_vel;
    w_prog_nx = r_program;
    w_gate_nx = r_gate;
    w_stb_nx  = 1'b0;
    if (w_exec && r_match) begin
      case (r_type)
        NOTE_ON, NOTE_OFF: begin
          if (r_type == NOTE_ON && w_e_d2 != 7'd0) begin
            w_num_nx  = w_e_d1;
            w_vel_nx  = w_e_d2;
            w_gate_nx = 1'b1;
            w_stb_nx  = 1'b1;
          end else if (r_gate && w_e_d1 == r_note_num) begin
            w_gate_nx = 1'b0;
            w_vel_nx  = 7'd0;
          end
        end
        PROG: w_prog_nx = w_e_d1;
        CTRL: begin
          if (w_e_d1 == ALL_SOUND_OFF || w_e_d1 == ALL_NOTES_OFF) begin
            w_gate_nx = 1'b0;
            w_vel_nx  = 7'd0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= IDLE;
      r_type     <= 4'd0;
      r_match    <= 1'b0;
      r_d1       <= 7'd0;
      r_note_num <= 7'd0;
      r_note_vel <= 7'd0;
      r_program  <= 7'd0;
      r_gate     <= 1'b0;
      r_note_stb <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_type     <= w_type_nx;
      r_match    <= w_match_nx;
      r_d1       <= w_d1_nx;
      r_note_num <= w_num_nx;
      r_note_vel <= w_vel_nx;
      r_program  <= w_prog_nx;
      r_gate     <= w_gate_nx;
      r_note_stb <= w_stb_nx;
    end
  end

  assign o_note_num = r_note_num;
  assign o_note_vel = r_note_vel;
  assign o_program  = r_program;
  assign o_gate     = r_gate;
  assign o_note_stb = r_note_stb;

endmodule

// File: doc/midi_decoder.md
Name: midi_decoder

Overview:
- Parses the MIDI byte stream from the UART receiver into the NOTE_NUM / NOTE_VEL / PROGRAM control words that feed the oscillator stage directly.
- Monophonic with last-note priority. Supports running status and channel filtering.
- Silencing is done by forcing NOTE_VEL to 0, so the downstream volume lookup outputs silence with no extra gating.

Parameters:
- CHANNEL, 0, MIDI channel (0-15) this decoder responds to; messages on other channels are parsed but discarded.

Ports:
- CLK  in  1  system clock
- RST  in  1  reset, asynchronous, active-high
- RX_DATA  in  8  received byte from UART receiver
- RX_VALID  in  1  one-cycle strobe; RX_DATA valid this cycle
- NOTE_NUM  out  7  current note number
- NOTE_VEL  out  7  current velocity; 0 = silent
- PROGRAM  out  7  current program (waveform select)
- GATE  out  1  high while a note is held
- NOTE_STB  out  1  one-cycle pulse when NOTE_NUM/NOTE_VEL change due to a note-on

Behaviour:
- Reset (async, active-high): NOTE_NUM=0, NOTE_VEL=0, PROGRAM=0, GATE=0, NOTE_STB=0, running status cleared, state IDLE.
- Bytes are consumed only on cycles with RX_VALID=1. All outputs are registered. An output update appears one cycle after the RX_VALID of the byte that completes a message.
- Byte classes:
  - RX_DATA[7]=0: data byte.
  - 0x80-0xEF: channel voice status.
  - 0xF0-0xF7: system common.
  - 0xF8-0xFF: realtime.
- Realtime bytes: ignored completely. They do not change state or running status and may appear between data bytes.
- System common bytes: clear running status and go to IDLE. Following data bytes (e.g. sysex payload) are dropped until the next voice status.
- Voice status: latch the status byte (type nibble plus channel-match flag), go to WAIT_D1. Any partially received message is abandoned.
- States:
  - IDLE: data bytes dropped.
  - WAIT_D1: data byte -> store as D1. For 1-byte types (Cx, Dx), execute, stay in WAIT_D1. Otherwise go to WAIT_D2.
  - WAIT_D2: data byte -> execute with D1/D2, return to WAIT_D1 (running status retained).
- Execution applies only if the latched channel equals CHANNEL; otherwise no output changes.
  - 9x, D2!=0 (note on): NOTE_NUM=D1, NOTE_VEL=D2, GATE=1, NOTE_STB=1 for one cycle. A new note always replaces the old one (last-note priority).
  - 8x, or 9x with D2=0 (note off): if D1==NOTE_NUM and GATE=1, then GATE=0 and NOTE_VEL=0; NOTE_NUM keeps its value. Otherwise no change.
  - Cx (program change): PROGRAM=D1.
  - Bx with D1=123 or D1=120 (all notes off / all sound off): GATE=0, NOTE_VEL=0.
  - Other Bx, Ax, Ex, Dx: consumed and discarded.
- NOTE_STB is 0 in every cycle other than the single pulse described above.
- Reset mid-message: everything returns to reset values. The next data byte is dropped because state is IDLE.
- RX_VALID is never asserted on consecutive cycles by the UART. The decoder must nonetheless accept back-to-back strobes correctly (one byte per cycle).

Decomposition:
- Shared package midi_pkg holds:
  - status type nibble constants: NOTE_OFF=8, NOTE_ON=9, POLY_AT=A, CTRL=B, PROG=C, CHAN_AT=D, PITCH=E
  - CC numbers ALL_SOUND_OFF=120, ALL_NOTES_OFF=123
  - state encoding IDLE/WAIT_D1/WAIT_D2
  - helper giving the data-byte count for a type nibble
- No sub-module. The UART receiver is a separate existing block upstream. The FSM and output registers live in one module.

Test Plan:
- 0x90,0x3C,0x64 (CHANNEL=0) -> one cycle after third strobe: NOTE_NUM=60, NOTE_VEL=100, GATE=1, NOTE_STB pulse of exactly one cycle.
- Running status 0x90,0x3C,0x64,0x40,0x50 -> second note-on executes: NOTE_NUM=64, NOTE_VEL=80; then 0x3C,0x00 -> no change, because 60 is not the current note.
- 0x80,0x40,0x00 after note 64 held -> GATE=0, NOTE_VEL=0, NOTE_NUM stays 64; 0x90,0x40,0xF8,0x7F (clock byte interleaved) -> note-on 64 vel 127.
- 0xC0,0x05 -> PROGRAM=5; 0xC3,0x07 with CHANNEL=0 -> PROGRAM stays 5; 0xB0,0x7B,0x00 while a note is held -> GATE=0, NOTE_VEL=0.
- 0xF0,0x3C,0x64,0xF7,0x3C,0x64 -> no output change (sysex payload and post-F7 data dropped, running status cleared).
- Assert RST between 0x90 and 0x3C -> outputs reset immediately; subsequent 0x3C,0x64 -> no change.
